mul_add_unsigned_seq: RTL and testbench

//   Sequential unsigned shift-add multiply-accumulate: p = q*b + r.

---
 rtl/mul_add_unsigned_seq.sv | 108 ++++++++++
 tb/tb_mul_add_unsigned_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mul_add_unsigned_seq.sv
// rtl/mul_add_unsigned_seq.sv - sequential unsigned shift-add multiply-accumulate p = q*b + r
module mul_add_unsigned_seq #(
    parameter int N = 17,
    parameter int M = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     q,
    input  logic [M-1:0]     b,
    input  logic [M-1:0]     r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   p
);

    localparam int W  = N + M;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   acc;
    logic [W-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   acc_nxt;
    logic           accept;
    logic           last_step;
    logic           release_out;

    assign accept      = (state == IDLE) && in_valid;
    assign last_step   = (state == RUN) && (cnt == '0);
    assign release_out = (state == DONE) && out_ready;

    // Width W always holds (2^M-1)*2^N, so this add never wraps.
    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (release_out) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            if (accept) begin
                acc    <= {{N{1'b0}}, r};
                mcand  <= {{N{1'b0}}, b};
                mplier <= q;
                cnt    <= CW'(N - 1);
            end else if (state == RUN) begin
                acc    <= acc_nxt;
                mcand  <= {mcand[W-2:0], 1'b0};
                mplier <= {1'b0, mplier[N-1:1]};
                if (!last_step) begin
                    cnt <= cnt - 1'b1;
                end
            end
            // p is only refreshed on entry to DONE and otherwise holds the last result.
            if (last_step) begin
                p <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mul_add_unsigned_seq.sv
// tb/tb_mul_add_unsigned_seq.sv - self-checking bench for mul_add_unsigned_seq
module tb_mul_add_unsigned_seq;

    localparam int N = 17;
    localparam int M = 9;
    localparam int W = N + M;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  q;
    logic [M-1:0]  b;
    logic [M-1:0]  r;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  p;

    int checks = 0;
    int errors = 0;

    mul_add_unsigned_seq #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .b         (b),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] vq;
        logic [M-1:0] vb;
        logic [M-1:0] vr;
        logic [W-1:0] vp;
        string        name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand set, wait for the handshake, and return once out_valid is seen.
    task automatic start_and_wait(input logic [N-1:0] tq, input logic [M-1:0] tb,
                                  input logic [M-1:0] tr, output int lat);
        int k;
        q = tq;
        b = tb;
        r = tr;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            step();
            k++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        q = '1;
        b = '1;
        r = '1;
        lat = 0;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        if (!out_valid) chk("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic do_op(input logic [N-1:0] tq, input logic [M-1:0] tb, input logic [M-1:0] tr,
                         input logic [W-1:0] exp, input string name,
                         input int igap, input int ogap, input bit chk_lat);
        int lat;
        repeat (igap) step();
        start_and_wait(tq, tb, tr, lat);
        if (chk_lat) chk({name, "_latency"}, 32'(lat), 32'(N));
        chk(name, 32'(p), 32'(exp));
        repeat (ogap) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (chk_lat) begin
            chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
            chk({name, "_p_held"}, 32'(p), 32'(exp));
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   lat;
        logic [W-1:0] held;

        vecs[0] = '{17'd100,   9'd7,   9'd3,   26'd703,       "basic"};
        vecs[1] = '{17'h1FFFF, 9'd511, 9'd511, 26'h3FE0000,   "max"};
        vecs[2] = '{17'd1234,  9'd0,   9'd5,   26'd5,         "b_zero"};
        vecs[3] = '{17'd0,     9'd9,   9'd0,   26'd0,         "q_zero"};
        vecs[4] = '{17'd1,     9'd1,   9'd0,   26'd1,         "ones"};
        vecs[5] = '{17'd3,     9'd511, 9'd0,   26'd1533,      "small_q"};
        vecs[6] = '{17'h10000, 9'd256, 9'd1,   26'h1000001,   "top_bits"};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q = '0;
        b = '0;
        r = '0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_p", 32'(p), 32'd0);
        step();
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            do_op(vecs[i].vq, vecs[i].vb, vecs[i].vr, vecs[i].vp, vecs[i].name, 0, 0, 1'b1);
        end

        // Asynchronous abort in the middle of RUN; p holds a nonzero result beforehand.
        q = 17'd100;
        b = 9'd7;
        r = 9'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_p", 32'(p), 32'd0);
        step();
        rst = 1'b0;
        repeat (N + 3) step();
        chk("abort_no_spurious_valid", 32'(out_valid), 32'd0);
        do_op(17'd100, 9'd7, 9'd3, 26'd703, "after_abort", 0, 0, 1'b1);

        // Backpressure in DONE with a competing in_valid.
        start_and_wait(17'd4321, 9'd77, 9'd50, lat);
        held = p;
        chk("bp_result", 32'(held), 32'(4321 * 77 + 50));
        in_valid = 1'b1;
        q = 17'd5;
        b = 9'd5;
        r = 9'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_p_stable", 32'(p), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_no_new_op", 32'(in_ready), 32'd1);

        // Divider round trip with random handshake gaps.
        for (int i = 0; i < 1000; i++) begin
            int unsigned a, db, dq, dr;
            db = $urandom_range(511, 1);
            a  = $urandom % (db << N);
            dq = a / db;
            dr = a % db;
            do_op(N'(dq), M'(db), M'(dr), W'(a), "roundtrip",
                  $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
